scan_mux: RTL and testbench

Parametrised, time-multiplexed display scanner driving a shared digit data bus. It cycles through `NCH` channels of `W`-bit data with a programmable dwell time per channel, an inter-digit blanking gap, a runtime channel-enable mask and a frame-complete pulse. It sits between the counter/BCD logic and the 7-segment decoder/digit drivers, and supersedes the fixed three-input, one-clock-per-digit scanner.

---
 rtl/scan_mux.sv | 136 +++++++++++++
 tb/tb_scan_mux.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// Time-multiplexed display scanner: walks the enabled channels of a shared digit bus,
// inserting a blanking gap before each dwell period and pulsing frame_done on wrap.
module scan_mux #(
  parameter int NCH   = 4,
  parameter int W     = 4,
  parameter int DWELL = 1000,
  parameter int BLANK = 2,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NCH-1:0]    ch_mask,
  input  logic [NCH*W-1:0]  din,
  output logic [W-1:0]      data_out,
  output logic [SELW-1:0]   sel,
  output logic [NCH-1:0]    dig_en,
  output logic              frame_done
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SELW-1:0] entry_sel;
  logic [SELW-1:0] adv_sel;

  // First set mask bit at or above start, wrapping; returns start if none is set.
  function automatic logic [SELW-1:0] find_from(input logic [SELW-1:0] start,
                                                input logic [NCH-1:0]  mask);
    logic [SELW-1:0] r;
    logic            hit;
    r   = start;
    hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      int idx;
      idx = (int'(start) + i) % NCH;
      if (!hit && mask[idx]) begin
        r   = SELW'(idx);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] s);
    logic [NCH-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  assign entry_sel = find_from(sel, ch_mask);
  assign adv_sel   = find_from(SELW'((int'(sel) + 1) % NCH), ch_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sel        <= '0;
      data_out   <= '0;
      dig_en     <= '0;
      frame_done <= 1'b0;
    end else if (!en) begin
      // sel is deliberately kept so a re-enable resumes where the scan stopped
      state      <= S_IDLE;
      cnt        <= '0;
      data_out   <= '0;
      dig_en     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ch_mask != '0) begin
            sel <= entry_sel;
            cnt <= '0;
            if (BLANK == 0) begin
              state    <= S_SHOW;
              data_out <= din[int'(entry_sel)*W +: W];
              dig_en   <= onehot(entry_sel);
            end else begin
              state    <= S_BLANK;
              data_out <= '0;
              dig_en   <= '0;
            end
          end
        end
        S_BLANK: begin
          if (int'(cnt) == BLANK - 1) begin
            state    <= S_SHOW;
            cnt      <= '0;
            data_out <= din[int'(sel)*W +: W];
            dig_en   <= onehot(sel);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SHOW: begin
          if (int'(cnt) == DWELL - 1) begin
            cnt <= '0;
            if (ch_mask == '0) begin
              state    <= S_IDLE;
              data_out <= '0;
              dig_en   <= '0;
            end else begin
              // a non-increasing select means the scan wrapped past the top channel
              sel        <= adv_sel;
              frame_done <= (adv_sel <= sel);
              if (BLANK == 0) begin
                data_out <= din[int'(adv_sel)*W +: W];
                dig_en   <= onehot(adv_sel);
              end else begin
                state    <= S_BLANK;
                data_out <= '0;
                dig_en   <= '0;
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          cnt      <= '0;
          data_out <= '0;
          dig_en   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: a BLANK=1 and a BLANK=0 build share stimulus and are checked
// every cycle against a slot-phase model, plus directed literal expectations.
module tb_scan_mux;

  localparam int NCH   = 4;
  localparam int W     = 4;
  localparam int DWELL = 3;
  localparam int BL0   = 1;
  localparam int BL1   = 0;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  ch_mask;
  logic [15:0] din;
  logic [3:0]  data0, data1;
  logic [1:0]  sel0, sel1;
  logic [3:0]  dig0, dig1;
  logic        fd0, fd1;

  scan_mux #(.NCH(NCH), .W(W), .DWELL(DWELL), .BLANK(BL0)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .din(din),
    .data_out(data0), .sel(sel0), .dig_en(dig0), .frame_done(fd0)
  );

  scan_mux #(.NCH(NCH), .W(W), .DWELL(DWELL), .BLANK(BL1)) dut_nb (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .din(din),
    .data_out(data1), .sel(sel1), .dig_en(dig1), .frame_done(fd1)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: each build is idle or at a phase 0..BLANK+DWELL-1 inside its current slot
  bit         m_idle  [2];
  int         m_sel   [2];
  int         m_phase [2];
  bit         m_wr    [2];
  logic [3:0] m_lat   [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  function automatic int blank_of(input int k);
    return (k == 0) ? BL0 : BL1;
  endfunction

  function automatic logic [3:0] din_ch(input logic [15:0] d, input int c);
    return d[c*4 +: 4];
  endfunction

  // lowest enabled channel >= s, otherwise lowest enabled channel overall
  function automatic int first_from(input int s, input logic [3:0] m);
    for (int i = s; i < NCH; i++) if (m[i]) return i;
    for (int i = 0; i < NCH; i++) if (m[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit         idle, wr;
    int         s, ph, bk, ns;
    logic [3:0] lat;
    for (int k = 0; k < 2; k++) begin
      idle = m_idle[k]; wr = m_wr[k]; s = m_sel[k]; ph = m_phase[k]; lat = m_lat[k];
      bk = blank_of(k);
      if (rst) begin
        idle = 1'b1; s = 0; ph = 0; wr = 1'b0; lat = '0;
      end else if (!en) begin
        idle = 1'b1; ph = 0; wr = 1'b0;
      end else if (idle) begin
        if (ch_mask != 4'b0) begin
          s = first_from(s, ch_mask); idle = 1'b0; ph = 0; wr = 1'b0;
          if (ph == bk) lat = din_ch(din, s);
        end
      end else begin
        ph++;
        wr = 1'b0;
        if (ph == bk + DWELL) begin
          ph = 0;
          if (ch_mask == 4'b0) idle = 1'b1;
          else begin
            ns = first_from((s + 1) % NCH, ch_mask);
            wr = (ns <= s);
            s  = ns;
          end
        end
        if (!idle && ph == bk) lat = din_ch(din, s);
      end
      m_idle[k] <= idle; m_wr[k] <= wr; m_sel[k] <= s; m_phase[k] <= ph; m_lat[k] <= lat;
    end
  end

  function automatic bit vis(input int k);
    return !m_idle[k] && (m_phase[k] >= blank_of(k));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every cycle, both builds against the model
  always @(negedge clk) begin
    if (checking) begin
      chk("b1 sel", 32'(sel0), 32'(m_sel[0]));
      chk("b1 dig_en", 32'(dig0), vis(0) ? (32'd1 << m_sel[0]) : 32'd0);
      chk("b1 data_out", 32'(data0), vis(0) ? 32'(m_lat[0]) : 32'd0);
      chk("b1 frame_done", 32'(fd0), 32'(!m_idle[0] && m_phase[0] == 0 && m_wr[0]));
      chk("b0 sel", 32'(sel1), 32'(m_sel[1]));
      chk("b0 dig_en", 32'(dig1), vis(1) ? (32'd1 << m_sel[1]) : 32'd0);
      chk("b0 data_out", 32'(data1), vis(1) ? 32'(m_lat[1]) : 32'd0);
      chk("b0 frame_done", 32'(fd1), 32'(!m_idle[1] && m_phase[1] == 0 && m_wr[1]));
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_show(input int s);
    int n;
    n = 0;
    while (!(!m_idle[0] && m_sel[0] == s && m_phase[0] == BL0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wait_show timeout", 32'(n), 32'd0);
  endtask

  task automatic count_window(input int n, input bit nb_sel_chk,
                              output int f0, output int b0, output int f1, output int b1);
    f0 = 0; b0 = 0; f1 = 0; b1 = 0;
    repeat (n) begin
      @(negedge clk);
      f0 += int'(fd0);
      b0 += int'(dig0 == 4'b0);
      f1 += int'(fd1);
      b1 += int'(dig1 == 4'b0);
      if (nb_sel_chk && fd1) chk("b0 frame_done with sel 0", 32'(sel1), 32'd0);
    end
  endtask

  initial begin
    int f0, b0, f1, b1;
    rst = 1'b0; en = 1'b0; ch_mask = 4'b0; din = 16'hDCBA;
    #1 rst = 1'b1;
    #1;
    chk("reset data_out", 32'(data0), 32'd0);
    chk("reset sel", 32'(sel0), 32'd0);
    chk("reset dig_en", 32'(dig0), 32'd0);
    chk("reset frame_done", 32'(fd0), 32'd0);
    @(negedge clk);
    checking = 1'b1;
    rst = 1'b0; en = 1'b1; ch_mask = 4'b1111;
    tick(1);
    chk("entry blank dig_en", 32'(dig0), 32'd0);
    tick(1);
    chk("first show dig_en", 32'(dig0), 32'b0001);
    chk("first show data", 32'(data0), 32'hA);
    tick(3);
    chk("second slot sel", 32'(sel0), 32'd1);
    tick(1);

    // reset while channel 1 is shown
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst data_out", 32'(data0), 32'd0);
    chk("async rst dig_en", 32'(dig0), 32'd0);
    chk("async rst sel", 32'(sel0), 32'd0);
    chk("async rst frame_done", 32'(fd0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    chk("post rst blank", 32'(dig0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("post rst dig_en", 32'(dig0), 32'b0001);
      chk("post rst data", 32'(data0), 32'hA);
    end

    count_window(16, 1'b0, f0, b0, f1, b1);
    chk("mask1111 frame pulses", 32'(f0), 32'd1);
    chk("mask1111 blank cycles", 32'(b0), 32'd4);

    ch_mask = 4'b1010;
    tick(20);
    count_window(16, 1'b0, f0, b0, f1, b1);
    chk("mask1010 frame pulses", 32'(f0), 32'd2);
    chk("mask1010 blank cycles", 32'(b0), 32'd4);

    ch_mask = 4'b0100;
    tick(20);
    count_window(16, 1'b0, f0, b0, f1, b1);
    chk("mask0100 frame pulses", 32'(f0), 32'd4);
    chk("mask0100 blank cycles", 32'(b0), 32'd4);
    chk("mask0100 sel", 32'(sel0), 32'd2);

    // mask cleared while channel 1 is shown
    ch_mask = 4'b1111;
    wait_show(1);
    ch_mask = 4'b0;
    tick(1);
    chk("mask0 slot completes", 32'(data0), 32'hB);
    tick(2);
    chk("mask0 idle dig_en", 32'(dig0), 32'd0);
    chk("mask0 idle data", 32'(data0), 32'd0);
    chk("mask0 idle sel", 32'(sel0), 32'd1);
    tick(3);
    chk("mask0 stays idle", 32'(dig0), 32'd0);

    // en dropped mid-slot, then resumed
    ch_mask = 4'b1111;
    wait_show(1);
    en = 1'b0;
    tick(1);
    chk("en low dig_en", 32'(dig0), 32'd0);
    chk("en low data", 32'(data0), 32'd0);
    chk("en low sel kept", 32'(sel0), 32'd1);
    tick(1);
    en = 1'b1;
    tick(1);
    chk("resume blank", 32'(dig0), 32'd0);
    chk("resume sel", 32'(sel0), 32'd1);
    tick(1);
    chk("resume dig_en", 32'(dig0), 32'b0010);
    chk("resume data", 32'(data0), 32'hB);

    // din change during a slot is not visible until the next visit
    wait_show(2);
    din = 16'hD5BA;
    tick(1);
    chk("data hold", 32'(data0), 32'hC);
    tick(1);
    wait_show(2);
    chk("data next visit", 32'(data0), 32'h5);
    din = 16'hDCBA;

    tick(20);
    count_window(12, 1'b1, f0, b0, f1, b1);
    chk("noblank frame pulses", 32'(f1), 32'd1);
    chk("noblank blank cycles", 32'(b1), 32'd0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) ch_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) din = 16'($urandom);
      en = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 199) == 0) begin
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rand async rst dig_en", 32'(dig0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
      end
    end

    tick(1);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
